snake_mover: RTL and testbench
==============================

SNAKE_MOVER -- requirements
Module: snake_mover

Interface
REQ-001 Parameters SHALL be: MAX_LEN, default 32, segment buffer depth; X_MAX, default 160, screen width in pixels; Y_MAX, default 120, screen height in pixels; SNAKE_COLOR, default 3'b010, head draw colour.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLOCK_50, in, 1, sole clock.
- Reset, in, 1, synchronous, active-high.
- step, in, 1, one-cycle move tick.
- dir, in, 2, requested direction: 00 right, 01 up, 10 left, 11 down.
- grow, in, 1, one-cycle grow request.
- plot_x, out, 8, pixel x.
- plot_y, out, 7, pixel y.
- plot_color, out, 3, pixel colour.
- plot_valid, out, 1, pixel request.
- plot_ready, in, 1, downstream VGA plotter accepts.
- busy, out, 1, step in progress.
- dead, out, 1, collision occurred.
- length, out, 6, current segment count.

Function
REQ-003 Segment coordinates SHALL be held in a MAX_LEN-entry circular buffer with head and tail pointers that wrap from MAX_LEN-1 to 0.
REQ-004 FSM states SHALL be INIT, IDLE, CALC, CHECK, ERASE, DRAW, DEAD.
REQ-005 INIT SHALL plot the 3 reset segments, tail first, in SNAKE_COLOR, one per accepted handshake, then go to IDLE.
REQ-006 A plot transfer SHALL complete only on a cycle with plot_valid=1 and plot_ready=1; plot_x, plot_y and plot_color SHALL stay stable while plot_valid=1 and plot_ready=0.
REQ-007 In IDLE, step=1 SHALL latch dir and go to CALC next cycle; busy SHALL be 1 in every state except IDLE and DEAD.
REQ-008 step asserted while busy=1 or in DEAD SHALL be ignored, with no queuing.
REQ-009 A dir that reverses the current direction (right/left or up/down) SHALL be ignored; the current direction is kept.
REQ-010 CALC SHALL compute the new head as the current head plus or minus 1 on one axis.
REQ-011 CALC SHALL go to DEAD if the head is at x=0 moving left, x=X_MAX-1 moving right, y=0 moving up, or y=Y_MAX-1 moving down; otherwise it goes to CHECK.
REQ-012 grow=1 in any state except DEAD SHALL set a pending flag, consumed by the next accepted step.
REQ-013 If the pending flag is set and length<MAX_LEN, the step SHALL grow: tail not popped, ERASE skipped, length incremented.
REQ-014 At length=MAX_LEN a pending grow SHALL be cleared with no effect.
REQ-015 On a normal step, ERASE SHALL plot the old tail with colour 3'b000, then pop the tail.
REQ-016 DRAW SHALL plot the new head in SNAKE_COLOR, push it at the head pointer, then return to IDLE.
REQ-017 From step acceptance to IDLE, latency SHALL be 2 + CHECK cycles + plot handshake cycles.

Reset
REQ-018 Reset=1 SHALL dominate all inputs in every state, including mid-handshake.
REQ-019 Reset SHALL load: length=3; segments (78,60) tail, (79,60), (80,60) head; direction right; pending grow cleared; dead=0; plot_valid=0; plot_x=0; plot_y=0; plot_color=0; busy=1; state INIT.

Configuration
REQ-020 With SELF_COLLISION_EN defined, CHECK SHALL compare the new head against each live segment, one per cycle; on a normal step it excludes the tail, which is vacated.
REQ-021 With SELF_COLLISION_EN defined, any match in CHECK SHALL go to DEAD.
REQ-022 Without SELF_COLLISION_EN, CHECK SHALL take 0 cycles, going directly to ERASE or DRAW, and self-overlap SHALL be permitted.

Verification
REQ-023 Scenario: after reset with plot_ready=1 -> plots (78,60), (79,60), (80,60) colour 010, then busy=0.
REQ-024 Scenario: step with dir=00 and plot_ready=1 -> erase (78,60) colour 000, draw (81,60), length=3.
REQ-025 Scenario: grow pulse then step with dir=01 -> no erase, draw (80,59), length=4.
REQ-026 Scenario: dir=10 while moving right -> direction stays right, head becomes (81,60).
REQ-027 Scenario: head at (159,y), step with dir=00 -> dead=1, no plot_valid, further steps ignored until Reset.
REQ-028 Scenario: plot_ready held 0 for 5 cycles during ERASE -> coordinates stable, single transfer; Reset mid-ERASE -> re-INIT.

Source files
------------

// File: rtl/snake_mover.sv
// Snake body mover: circular segment buffer, wall detection and VGA plot handshaking.
// Define SELF_COLLISION_EN to enable the per-segment head-vs-body check in CHECK.
module snake_mover #(
  parameter int          MAX_LEN     = 32,
  parameter int          X_MAX       = 160,
  parameter int          Y_MAX       = 120,
  parameter logic [2:0]  SNAKE_COLOR = 3'b010
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic       step,
  input  logic [1:0] dir,
  input  logic       grow,
  output logic [7:0] plot_x,
  output logic [6:0] plot_y,
  output logic [2:0] plot_color,
  output logic       plot_valid,
  input  logic       plot_ready,
  output logic       busy,
  output logic       dead,
  output logic [5:0] length
);

  localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {INIT, IDLE, CALC, CHECK, ERASE, DRAW, DEAD} state_t;

  state_t           state;
  logic [7:0]       seg_x [MAX_LEN];
  logic [6:0]       seg_y [MAX_LEN];
  logic [PTR_W-1:0] head_ptr, tail_ptr, init_ptr;
  logic [1:0]       init_cnt;
  logic [1:0]       cur_dir;
  logic             grow_pend, do_grow;
  logic [7:0]       head_x, nx, new_x, draw_x;
  logic [6:0]       head_y, ny, new_y, draw_y;
  logic             hit_wall;
`ifdef SELF_COLLISION_EN
  logic [PTR_W-1:0] chk_ptr;
  logic [5:0]       chk_cnt;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_LEN - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_x = seg_x[head_ptr];
  assign head_y = seg_y[head_ptr];
  assign busy   = (state != IDLE) && (state != DEAD);
  assign dead   = (state == DEAD);

  // Next head position and wall test for the latched direction.
  always_comb begin
    nx       = head_x;
    ny       = head_y;
    hit_wall = 1'b0;
    case (cur_dir)
      2'b00: begin nx = head_x + 8'd1; hit_wall = (head_x == 8'(X_MAX - 1)); end
      2'b01: begin ny = head_y - 7'd1; hit_wall = (head_y == 7'd0); end
      2'b10: begin nx = head_x - 8'd1; hit_wall = (head_x == 8'd0); end
      default: begin ny = head_y + 7'd1; hit_wall = (head_y == 7'(Y_MAX - 1)); end
    endcase
  end

  // The head drawn after CHECK comes from the registered copy; without CHECK it is launched straight from CALC.
`ifdef SELF_COLLISION_EN
  assign draw_x = new_x;
  assign draw_y = new_y;
`else
  assign draw_x = nx;
  assign draw_y = ny;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state      <= INIT;
      seg_x[0]   <= 8'd78;
      seg_x[1]   <= 8'd79;
      seg_x[2]   <= 8'd80;
      seg_y[0]   <= 7'd60;
      seg_y[1]   <= 7'd60;
      seg_y[2]   <= 7'd60;
      tail_ptr   <= '0;
      head_ptr   <= PTR_W'(2);
      init_ptr   <= '0;
      init_cnt   <= 2'd0;
      length     <= 6'd3;
      cur_dir    <= 2'b00;
      grow_pend  <= 1'b0;
      do_grow    <= 1'b0;
      new_x      <= 8'd0;
      new_y      <= 7'd0;
      plot_valid <= 1'b0;
      plot_x     <= 8'd0;
      plot_y     <= 7'd0;
      plot_color <= 3'b000;
`ifdef SELF_COLLISION_EN
      chk_ptr    <= '0;
      chk_cnt    <= 6'd0;
`endif
    end else begin
      if (grow && state != DEAD)
        grow_pend <= 1'b1;
      case (state)
        INIT: begin
          if (!plot_valid) begin
            plot_x     <= seg_x[init_ptr];
            plot_y     <= seg_y[init_ptr];
            plot_color <= SNAKE_COLOR;
            plot_valid <= 1'b1;
          end else if (plot_ready) begin
            plot_valid <= 1'b0;
            init_ptr   <= ptr_inc(init_ptr);
            if (init_cnt == 2'd2) state <= IDLE;
            else init_cnt <= init_cnt + 2'd1;
          end
        end
        IDLE: begin
          if (step) begin
            if ((dir ^ cur_dir) != 2'b10)
              cur_dir <= dir;
            do_grow   <= (grow_pend || grow) && (length < 6'(MAX_LEN));
            grow_pend <= 1'b0;
            state     <= CALC;
          end
        end
        CALC: begin
          if (hit_wall) begin
            state <= DEAD;
          end else begin
            new_x <= nx;
            new_y <= ny;
`ifdef SELF_COLLISION_EN
            state   <= CHECK;
            chk_ptr <= do_grow ? tail_ptr : ptr_inc(tail_ptr);
            chk_cnt <= do_grow ? length : length - 6'd1;
`else
            state      <= do_grow ? DRAW : ERASE;
            plot_x     <= do_grow ? draw_x : seg_x[tail_ptr];
            plot_y     <= do_grow ? draw_y : seg_y[tail_ptr];
            plot_color <= do_grow ? SNAKE_COLOR : 3'b000;
            plot_valid <= 1'b1;
`endif
          end
        end
`ifdef SELF_COLLISION_EN
        CHECK: begin
          if (seg_x[chk_ptr] == new_x && seg_y[chk_ptr] == new_y) begin
            state <= DEAD;
          end else if (chk_cnt == 6'd1) begin
            state      <= do_grow ? DRAW : ERASE;
            plot_x     <= do_grow ? draw_x : seg_x[tail_ptr];
            plot_y     <= do_grow ? draw_y : seg_y[tail_ptr];
            plot_color <= do_grow ? SNAKE_COLOR : 3'b000;
            plot_valid <= 1'b1;
          end else begin
            chk_ptr <= ptr_inc(chk_ptr);
            chk_cnt <= chk_cnt - 6'd1;
          end
        end
`endif
        ERASE: begin
          if (plot_ready) begin
            tail_ptr   <= ptr_inc(tail_ptr);
            plot_x     <= new_x;
            plot_y     <= new_y;
            plot_color <= SNAKE_COLOR;
            state      <= DRAW;
          end
        end
        DRAW: begin
          if (plot_ready) begin
            plot_valid               <= 1'b0;
            seg_x[ptr_inc(head_ptr)] <= new_x;
            seg_y[ptr_inc(head_ptr)] <= new_y;
            head_ptr                 <= ptr_inc(head_ptr);
            if (do_grow) length <= length + 6'd1;
            state <= IDLE;
          end
        end
        DEAD: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_mover.sv
// Scoreboard bench for snake_mover: a reference snake model queues expected plots, a monitor checks each handshake.
module tb_snake_mover;

  logic       CLOCK_50 = 1'b0;
  logic       Reset = 1'b1;
  logic       step = 1'b0;
  logic [1:0] dir = 2'b00;
  logic       grow = 1'b0;
  logic       plot_ready = 1'b1;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_color;
  logic       plot_valid, busy, dead;
  logic [5:0] length;

  snake_mover dut (
    .CLOCK_50(CLOCK_50), .Reset(Reset), .step(step), .dir(dir), .grow(grow),
    .plot_x(plot_x), .plot_y(plot_y), .plot_color(plot_color), .plot_valid(plot_valid),
    .plot_ready(plot_ready), .busy(busy), .dead(dead), .length(length)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_pass = 0;

  logic [17:0] sb [$];
  int          mx [$];
  int          my [$];
  logic [1:0]  mdir;
  bit          mpend, mdead;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Every accepted plot transfer must match the oldest expected entry.
  always @(negedge CLOCK_50) begin
    if (!Reset && plot_valid && plot_ready) begin
      if (sb.size() == 0) check("plot_unexpected", 32'(plot_valid), 32'd0);
      else check("plot", 32'({plot_x, plot_y, plot_color}), 32'(sb.pop_front()));
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic model_reset();
    mx = {78, 79, 80};
    my = {60, 60, 60};
    mdir = 2'b00;
    mpend = 1'b0;
    mdead = 1'b0;
    sb.delete();
    for (int i = 0; i < 3; i++) sb.push_back({8'(mx[i]), 7'(my[i]), 3'b010});
  endtask

  task automatic model_step(input logic [1:0] d);
    int hx, hy, nx, ny;
    if ((d ^ mdir) != 2'b10) mdir = d;
    hx = mx[mx.size()-1];
    hy = my[my.size()-1];
    nx = hx;
    ny = hy;
    case (mdir)
      2'b00: if (hx == 159) mdead = 1'b1; else nx = hx + 1;
      2'b01: if (hy == 0)   mdead = 1'b1; else ny = hy - 1;
      2'b10: if (hx == 0)   mdead = 1'b1; else nx = hx - 1;
      default: if (hy == 119) mdead = 1'b1; else ny = hy + 1;
    endcase
    if (mdead) return;
    if (!(mpend && mx.size() < 32)) begin
      sb.push_back({8'(mx[0]), 7'(my[0]), 3'b000});
      void'(mx.pop_front());
      void'(my.pop_front());
    end
    mpend = 1'b0;
    mx.push_back(nx);
    my.push_back(ny);
    sb.push_back({8'(nx), 7'(ny), 3'b010});
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < 200);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!plot_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(plot_valid), 32'd1);
  endtask

  task automatic post_checks(input string tag);
    check({tag, "_length"}, 32'(length), 32'(mx.size()));
    check({tag, "_dead"}, 32'(dead), 32'(mdead));
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_step(input logic [1:0] d, input string tag);
    model_step(d);
    dir = d;
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_idle(tag);
    post_checks(tag);
  endtask

  initial begin
    logic [17:0] held;
    model_reset();
    repeat (3) tick();
    check("rst_valid", 32'(plot_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_dead", 32'(dead), 32'd0);
    check("rst_length", 32'(length), 32'd3);
    check("rst_plot", 32'({plot_x, plot_y, plot_color}), 32'd0);
    Reset = 1'b0;
    wait_idle("init");
    post_checks("init");

    do_step(2'b00, "right");
    grow = 1'b1;
    mpend = 1'b1;
    tick();
    grow = 1'b0;
    do_step(2'b01, "grow_up");
    do_step(2'b11, "reverse_down");
    do_step(2'b10, "left");

    // A second step while busy must be dropped.
    model_step(2'b10);
    dir = 2'b10;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    dir = 2'b01;
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_idle("busy_step");
    post_checks("busy_step");

    // Downstream stall during ERASE.
    plot_ready = 1'b0;
    model_step(2'b00);
    dir = 2'b00;
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_valid("stall");
    held = sb[0];
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_hold", 32'({plot_x, plot_y, plot_color}), 32'(held));
      check("stall_valid_hold", 32'(plot_valid), 32'd1);
    end
    plot_ready = 1'b1;
    wait_idle("stall");
    post_checks("stall");

    // Reset in the middle of an ERASE handshake.
    plot_ready = 1'b0;
    dir = 2'b01;
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_valid("mid_erase");
    Reset = 1'b1;
    tick();
    check("mid_rst_valid", 32'(plot_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd1);
    check("mid_rst_length", 32'(length), 32'd3);
    model_reset();
    plot_ready = 1'b1;
    tick();
    Reset = 1'b0;
    wait_idle("reinit");
    post_checks("reinit");

    // Run right into the wall at x=159.
    for (int i = 0; i < 79; i++) do_step(2'b00, "to_wall");
    do_step(2'b00, "wall");
    check("wall_dead", 32'(dead), 32'd1);
    dir = 2'b01;
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (5) tick();
    check("dead_hold", 32'(dead), 32'd1);
    check("dead_busy", 32'(busy), 32'd0);
    check("dead_valid", 32'(plot_valid), 32'd0);
    post_checks("dead_step");

    Reset = 1'b1;
    model_reset();
    tick();
    tick();
    Reset = 1'b0;
    wait_idle("revive");
    check("revive_dead", 32'(dead), 32'd0);
    post_checks("revive");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1);
  end

endmodule
